// File: rtl/frogger_pkg.sv
// Shared types and default constants for the frog movement input path.
package frogger_pkg;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    DOWN  = 2'd1,
    LEFT  = 2'd2,
    RIGHT = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OFFER   = 2'd1,
    LOCKOUT = 2'd2
  } arb_state_t;

  localparam int DEF_SYNC_STAGES    = 2;
  localparam int DEF_LOCKOUT_CYCLES = 8;

endpackage

// File: rtl/key_sync_edge.sv
// One-key metastability synchronizer followed by a rising-edge detector.
module key_sync_edge
  import frogger_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic reset,
  input  logic key,
  output logic level,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_p;
  logic                   prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_p <= '0;
      prev   <= 1'b0;
    end else begin
      sync_p <= {sync_p[SYNC_STAGES-2:0], key};
      prev   <= sync_p[SYNC_STAGES-1];
    end
  end

  assign level = sync_p[SYNC_STAGES-1];
  assign rise  = level & ~prev;

endmodule

// File: rtl/move_arbiter.sv
// Synchronizes direction keys, latches presses as pending requests and grants them
// round-robin with a post-move lockout. Define AUTOREPEAT_EN for held-key repeats.
module move_arbiter
  import frogger_pkg::*;
#(
  parameter int NUM_KEYS       = 4,
  parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
  parameter int LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES,
  parameter int REPEAT_CYCLES  = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_KEYS-1:0]         key_in,
  input  logic                        move_ready,
  output logic                        move_valid,
  output logic [$clog2(NUM_KEYS)-1:0] move_dir,
  output logic                        busy,
  output logic [NUM_KEYS-1:0]         pending
);

  localparam int DIR_W   = $clog2(NUM_KEYS);
  localparam int CNT_MAX = (LOCKOUT_CYCLES > REPEAT_CYCLES) ? LOCKOUT_CYCLES : REPEAT_CYCLES;
  localparam int CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

  logic [NUM_KEYS-1:0] level;
  logic [NUM_KEYS-1:0] rise;
  logic [NUM_KEYS-1:0] set_req;
  logic [NUM_KEYS-1:0] clr_mask;
  logic                accept;
  logic [DIR_W-1:0]    rr_ptr;
  logic [DIR_W-1:0]    grant_idx;
  logic [DIR_W-1:0]    cand;
  logic [CNT_W-1:0]    cnt;
  arb_state_t          state;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_sync_edge #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
      .clk  (clk),
      .reset(reset),
      .key  (key_in[k]),
      .level(level[k]),
      .rise (rise[k])
    );
  end

`ifdef AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] REP_RELOAD = CNT_W'(REPEAT_CYCLES - 1);

  logic [CNT_W-1:0]    rep_cnt [NUM_KEYS];
  logic [NUM_KEYS-1:0] rep_fire;

  // A held key re-requests every REPEAT_CYCLES; the press edge itself restarts the period.
  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_rep
    assign rep_fire[k] = level[k] & ~rise[k] & (rep_cnt[k] == '0);

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        rep_cnt[k] <= '0;
      end else if (!level[k]) begin
        rep_cnt[k] <= '0;
      end else if (rise[k] || rep_fire[k]) begin
        rep_cnt[k] <= REP_RELOAD;
      end else begin
        rep_cnt[k] <= rep_cnt[k] - CNT_W'(1);
      end
    end
  end

  assign set_req = rise | rep_fire;
`else
  assign set_req = rise;
`endif

  assign accept = move_valid & move_ready;

  always_comb begin
    clr_mask = '0;
    if (accept) clr_mask[move_dir] = 1'b1;
  end

  // Set beats clear so a press landing on its own accept cycle is not dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pending <= '0;
    else        pending <= (pending & ~clr_mask) | set_req;
  end

  // Walk downward so the lowest offset from rr_ptr is the last (winning) assignment.
  always_comb begin
    grant_idx = rr_ptr;
    cand      = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      cand = DIR_W'((int'(rr_ptr) + i) % NUM_KEYS);
      if (pending[cand]) grant_idx = cand;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      move_valid <= 1'b0;
      move_dir   <= '0;
      busy       <= 1'b0;
      rr_ptr     <= '0;
      cnt        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|pending) begin
            move_dir   <= grant_idx;
            move_valid <= 1'b1;
            busy       <= 1'b1;
            state      <= OFFER;
          end
        end
        OFFER: begin
          if (move_ready) begin
            move_valid <= 1'b0;
            rr_ptr     <= DIR_W'((int'(move_dir) + 1) % NUM_KEYS);
            if (LOCKOUT_CYCLES > 0) begin
              cnt   <= CNT_W'(LOCKOUT_CYCLES - 1);
              state <= LOCKOUT;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end
        LOCKOUT: begin
          if (cnt == '0) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          move_valid <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_move_arbiter.sv
// Directed and randomized bench for move_arbiter (default build, no autorepeat).
module tb_move_arbiter;

  localparam int NK   = 4;
  localparam int LOCK = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] key_in;
  logic       move_ready;
  logic       move_valid;
  logic [1:0] move_dir;
  logic       busy;
  logic [3:0] pending;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  move_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .key_in    (key_in),
    .move_ready(move_ready),
    .move_valid(move_valid),
    .move_dir  (move_dir),
    .busy      (busy),
    .pending   (pending)
  );

  // Reference model: key history by edge number, request set, offer and lockout timing.
  logic [3:0] key_hist [0:4095];
  int         edge_n   = 0;
  int         rst_edge = 0;
  logic [3:0] m_pend   = '0;
  bit         m_off    = 1'b0;
  logic [1:0] m_dir    = '0;
  logic [1:0] m_ptr    = '0;
  int         m_acc    = -1000;
  bit         m_busy   = 1'b0;

  logic [1:0] got [$];
  int         gedge [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d at edge %0d", tag, obs, exp, edge_n);
    end
  endtask

  function automatic logic [3:0] key_at(input int e);
    if (e < 1 || e <= rst_edge) return 4'b0000;
    return key_hist[e];
  endfunction

  task automatic model_reset();
    rst_edge = edge_n;
    m_pend   = '0;
    m_off    = 1'b0;
    m_dir    = '0;
    m_ptr    = '0;
    m_acc    = -1000;
    m_busy   = 1'b0;
  endtask

  task automatic model_edge();
    logic [3:0] rise_v, old_p, clr;
    bit         acc;
    int         i;
    // Key sampled at edge n reaches the synchronized level after edge n+1.
    rise_v = key_at(edge_n - 2) & ~key_at(edge_n - 3);
    old_p  = m_pend;
    acc    = m_off && move_ready;
    clr    = '0;
    if (acc) clr[m_dir] = 1'b1;
    m_pend = (old_p & ~clr) | rise_v;
    if (m_off) begin
      if (acc) begin
        m_off = 1'b0;
        m_ptr = m_dir + 2'd1;
        m_acc = edge_n;
      end
    end else if ((edge_n - m_acc > LOCK) && (old_p != 4'b0000)) begin
      i = 0;
      while (!old_p[m_ptr + 2'(i)]) i++;
      m_dir = m_ptr + 2'(i);
      m_off = 1'b1;
    end
    m_busy = m_off || (edge_n - m_acc < LOCK);
  endtask

  task automatic step();
    logic       pre_acc;
    logic [1:0] pre_dir;
    pre_acc = move_valid & move_ready;
    pre_dir = move_dir;
    @(posedge clk);
    edge_n++;
    key_hist[edge_n] = key_in;
    model_edge();
    if (pre_acc === 1'b1) begin
      got.push_back(pre_dir);
      gedge.push_back(edge_n);
    end
    #1;
    chk("valid", 32'(move_valid), 32'(m_off));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("pending", 32'(pending), 32'(m_pend));
    if (m_off) chk("dir", 32'(move_dir), 32'(m_dir));
  endtask

  task automatic wait_valid(input int limit);
    int n = 0;
    while (move_valid !== 1'b1 && n < limit) begin
      step();
      n++;
    end
    chk("wait_valid", 32'(move_valid), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    #2;
    reset = 1'b1;
    model_reset();
  endtask

  initial begin
    int sample_edge, bc, stab;
    reset      = 1'b0;
    key_in     = '0;
    move_ready = 1'b0;
    #12;
    chk("rst_valid", 32'(move_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_dir", 32'(move_dir), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Single press: latency, one accept, eight busy lockout cycles.
    key_in     = 4'b0001;
    move_ready = 1'b1;
    step();
    sample_edge = edge_n;
    key_in      = '0;
    wait_valid(20);
    chk("latency", 32'(edge_n - sample_edge), 32'd3);
    chk("first_dir", 32'(move_dir), 32'd0);
    step();
    chk("t1_grants", 32'(got.size()), 32'd1);
    chk("t1_dir", 32'(got.size() > 0 ? got[0] : 2'd3), 32'd0);
    bc = int'(busy);
    for (int i = 0; i < 11; i++) begin
      step();
      bc += int'(busy);
    end
    chk("busy_len", 32'(bc), 32'd8);
    chk("t1_pend", 32'(pending), 32'd0);

    // All keys at once from pointer 0: offer + lockout + idle between accepts.
    do_reset();
    got.delete();
    gedge.delete();
    key_in     = 4'b1111;
    move_ready = 1'b1;
    step();
    key_in = '0;
    for (int i = 0; i < 50; i++) step();
    chk("rr_count", 32'(got.size()), 32'd4);
    for (int i = 0; i < 4 && i < got.size(); i++) chk("rr_order", 32'(got[i]), 32'(i));
    for (int i = 1; i < 4 && i < gedge.size(); i++)
      chk("rr_gap", 32'(gedge[i] - gedge[i-1]), 32'(LOCK + 2));

    // Held offer stays stable; key 0 queued meanwhile wins after pointer wraps from 3.
    got.delete();
    key_in     = 4'b0100;
    move_ready = 1'b0;
    step();
    key_in = '0;
    wait_valid(20);
    stab = 0;
    for (int i = 0; i < 20; i++) begin
      key_in = (i == 3) ? 4'b0001 : 4'b0000;
      step();
      if (move_valid === 1'b1 && move_dir === 2'd2) stab++;
    end
    key_in = '0;
    chk("hold_stable", 32'(stab), 32'd20);
    chk("hold_pend", 32'(pending), 32'b0101);
    move_ready = 1'b1;
    for (int i = 0; i < 16; i++) step();
    chk("wrap_count", 32'(got.size()), 32'd2);
    if (got.size() == 2) chk("wrap_dir", 32'(got[1]), 32'd0);

    // Re-press of key 1 reaching pending on its own accept edge.
    got.delete();
    move_ready = 1'b0;
    key_in     = 4'b0010;
    step();
    key_in = '0;
    wait_valid(20);
    chk("rep_dir", 32'(move_dir), 32'd1);
    key_in = 4'b0010;
    step();
    key_in = '0;
    step();
    move_ready = 1'b1;
    step();
    chk("repress_pend", 32'(pending[1]), 32'd1);
    for (int i = 0; i < 16; i++) step();
    chk("repress_count", 32'(got.size()), 32'd2);
    if (got.size() == 2) chk("repress_dir", 32'(got[1]), 32'd1);

    // Asynchronous reset in the middle of an offer.
    got.delete();
    move_ready = 1'b0;
    key_in     = 4'b1000;
    step();
    key_in = '0;
    wait_valid(20);
    #2;
    reset = 1'b0;
    #1;
    chk("async_valid", 32'(move_valid), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_pend", 32'(pending), 32'd0);
    model_reset();
    @(negedge clk);
    reset      = 1'b1;
    move_ready = 1'b1;
    for (int i = 0; i < 15; i++) step();
    chk("post_rst_grants", 32'(got.size()), 32'd0);

    // Held key without autorepeat gives a single grant.
    got.delete();
    key_in = 4'b1000;
    for (int i = 0; i < 60; i++) step();
    key_in = '0;
    for (int i = 0; i < 15; i++) step();
    chk("hold_grants", 32'(got.size()), 32'd1);
    if (got.size() == 1) chk("hold_dir", 32'(got[0]), 32'd3);

    // Randomized presses and backpressure against the model.
    for (int i = 0; i < 400; i++) begin
      key_in     = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0000;
      move_ready = 1'($urandom_range(0, 1));
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
